// File: rtl/cpu_mc.sv
// cpu_mc: multi-cycle RV-subset core (LUI, ADDI, ADD, SUB, LD/SD or LW/SW,
// BEQ, BGE, JAL, JALR, EBREAK) with one shared request/ack memory port.
// Each instruction is fetched (FETCH), executed (EXEC) and, for loads and
// stores, completed with a second memory transaction (MEM).
//
// Ports:
//   clk, reset            : clock and synchronous active-high reset
//   mem_req/mem_we        : transaction request; 1 = store, 0 = fetch or load
//   mem_addr/mem_wdata    : byte address and store data, held for the whole request
//   mem_rdata/mem_ack     : read data (instruction in [31:0]) and completion strobe
//   halt/illegal          : core stopped; stop caused by a bad encoding or alignment
//   dbg_raddr/dbg_rdata   : combinational register-file peek (x0 reads 0)
module cpu_mc #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack,
  output logic            halt,
  output logic            illegal,
  input  logic [4:0]      dbg_raddr,
  output logic [XLEN-1:0] dbg_rdata
);

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;
  // Doubleword access on RV64, word access on RV32.
  localparam logic [2:0] LS_F3     = (XLEN == 64) ? 3'b011 : 3'b010;
  localparam int         AL        = (XLEN == 64) ? 3 : 2;
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  state_t            state, state_n;
  logic [XLEN-1:0]   pc, pc_n;
  logic [31:0]       ir;
  logic [XLEN-1:0]   addr_q, wdata_q;
  logic              ill_q, ill_n;
  logic [XLEN-1:0]   regs [1:31];

  logic [6:0]        opcode, funct7;
  logic [2:0]        funct3;
  logic [4:0]        rd, rs1, rs2;
  logic signed [XLEN-1:0] rs1_v, rs2_v;
  logic signed [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic              is_store;

  logic              wb_en, ls_go, bad, taken;
  logic [XLEN-1:0]   wb_data, ls_addr, target;

  // Immediates are assembled sign-filled to 32 bits, then widened to XLEN.
  function automatic logic signed [XLEN-1:0] sx32(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  assign opcode   = ir[6:0];
  assign rd       = ir[11:7];
  assign funct3   = ir[14:12];
  assign rs1      = ir[19:15];
  assign rs2      = ir[24:20];
  assign funct7   = ir[31:25];
  assign is_store = (opcode == OP_STORE);

  assign imm_i = sx32({{20{ir[31]}}, ir[31:20]});
  assign imm_s = sx32({{20{ir[31]}}, ir[31:25], ir[11:7]});
  assign imm_b = sx32({{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0});
  assign imm_u = sx32({ir[31:12], 12'b0});
  assign imm_j = sx32({{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0});

  assign rs1_v     = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign rs2_v     = (rs2 == 5'd0) ? '0 : regs[rs2];
  assign dbg_rdata = (dbg_raddr == 5'd0) ? '0 : regs[dbg_raddr];

  // Outputs are forced quiet while reset is held, not only after the edge.
  assign mem_req   = !reset && (state == FETCH || state == MEM);
  assign mem_we    = !reset && (state == MEM) && is_store;
  assign mem_addr  = reset ? '0 : (state == FETCH) ? pc : (state == MEM) ? addr_q : '0;
  assign mem_wdata = (!reset && state == MEM && is_store) ? wdata_q : '0;
  assign halt      = !reset && (state == HALT);
  assign illegal   = !reset && (state == HALT) && ill_q;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    ill_n   = ill_q;
    wb_en   = 1'b0;
    wb_data = '0;
    ls_go   = 1'b0;
    ls_addr = '0;
    target  = '0;
    taken   = 1'b0;
    bad     = 1'b0;
    case (state)
      FETCH: if (mem_ack) state_n = EXEC;
      EXEC: begin
        state_n = FETCH;
        pc_n    = pc + FOUR;
        case (opcode)
          OP_LUI: begin
            wb_en   = 1'b1;
            wb_data = imm_u;
          end
          OP_IMM: begin
            if (funct3 == 3'b000) begin
              wb_en   = 1'b1;
              wb_data = rs1_v + imm_i;
            end else bad = 1'b1;
          end
          OP_REG: begin
            if (funct3 == 3'b000 && funct7 == 7'h00) begin
              wb_en   = 1'b1;
              wb_data = rs1_v + rs2_v;
            end else if (funct3 == 3'b000 && funct7 == 7'h20) begin
              wb_en   = 1'b1;
              wb_data = rs1_v - rs2_v;
            end else bad = 1'b1;
          end
          OP_LOAD, OP_STORE: begin
            if (funct3 == LS_F3) begin
              ls_addr = rs1_v + (is_store ? imm_s : imm_i);
              if (ls_addr[AL-1:0] != '0) bad = 1'b1;
              else begin
                ls_go   = 1'b1;
                state_n = MEM;
                pc_n    = pc;
              end
            end else bad = 1'b1;
          end
          OP_BRANCH: begin
            if (funct3 == 3'b000)      taken = (rs1_v == rs2_v);
            else if (funct3 == 3'b101) taken = (rs1_v >= rs2_v);
            else                       bad   = 1'b1;
            target = pc + imm_b;
            if (!bad && taken) begin
              if (target[1:0] != 2'b00) bad = 1'b1;
              else                      pc_n = target;
            end
          end
          OP_JAL: begin
            target = pc + imm_j;
            if (target[1:0] != 2'b00) bad = 1'b1;
            else begin
              pc_n    = target;
              wb_en   = 1'b1;
              wb_data = pc + FOUR;
            end
          end
          OP_JALR: begin
            if (funct3 == 3'b000) begin
              // rs1 is read before the rd write lands, so rd == rs1 is safe.
              target    = rs1_v + imm_i;
              target[0] = 1'b0;
              if (target[1] != 1'b0) bad = 1'b1;
              else begin
                pc_n    = target;
                wb_en   = 1'b1;
                wb_data = pc + FOUR;
              end
            end else bad = 1'b1;
          end
          OP_SYS: begin
            if (ir == EBREAK) begin
              state_n = HALT;
              ill_n   = 1'b0;
              pc_n    = pc;
            end else bad = 1'b1;
          end
          default: bad = 1'b1;
        endcase
        // Any fault suppresses the register write and the memory phase.
        if (bad) begin
          state_n = HALT;
          ill_n   = 1'b1;
          pc_n    = pc;
          wb_en   = 1'b0;
          ls_go   = 1'b0;
        end
      end
      MEM: begin
        if (mem_ack) begin
          state_n = FETCH;
          pc_n    = pc + FOUR;
          wb_en   = !is_store;
          wb_data = mem_rdata;
        end
      end
      HALT: ;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      pc    <= RESET_PC;
      ill_q <= 1'b0;
      for (int i = 1; i < 32; i++) regs[i] <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      ill_q <= ill_n;
      if (wb_en && rd != 5'd0) regs[rd] <= wb_data;
    end
  end

  // Instruction and load/store operands are pure data: no reset needed.
  always_ff @(posedge clk) begin
    if (state == FETCH && mem_ack) ir <= mem_rdata[31:0];
    if (ls_go) begin
      addr_q  <= ls_addr;
      wdata_q <= rs2_v;
    end
  end

endmodule

// File: tb/tb_cpu_mc.sv
// tb_cpu_mc: directed programs for cpu_mc with a memory model, an expected
// transaction queue filled by the stimulus, and a monitor that checks each
// completed memory transaction and request stability.
module tb_cpu_mc;
  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic            mem_req, mem_we, mem_ack, halt, illegal;
  logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata, dbg_rdata;
  logic [4:0]      dbg_raddr;

  cpu_mc #(.XLEN(XLEN), .RESET_PC('0)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .halt(halt), .illegal(illegal),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    int          cyc;
  } txn_t;

  txn_t        exp_q[$];
  logic [63:0] mem [logic [63:0]];
  int          checks = 0;
  int          errors = 0;
  int          wait_n = 0;
  int          wcnt   = 0;
  int          cursor = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory model: ack after wait_n extra cycles of a continuous request.
  always @(negedge clk) begin
    if (mem_req) begin
      if (wcnt >= wait_n) begin
        mem_ack = 1'b1;
        if (mem_we) mem[mem_addr] = mem_wdata;
        else        mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 64'h0;
        wcnt = 0;
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end
  end

  // Monitor: compares each handshake to the queue head, checks stability.
  int          cyc = 0;
  logic        prev_req = 1'b0, prev_hs = 1'b1, prev_we = 1'b0;
  logic [63:0] prev_addr = '0, prev_wdata = '0;
  always @(negedge clk) begin
    txn_t t;
    #1;
    if (reset) begin
      cyc = 0; prev_req = 1'b0; prev_hs = 1'b1;
    end else begin
      if (mem_req && prev_req && !prev_hs) begin
        chk("addr_stable", mem_addr, prev_addr);
        chk("we_stable", {63'b0, mem_we}, {63'b0, prev_we});
        chk("wdata_stable", mem_wdata, prev_wdata);
      end
      if (mem_req && mem_ack) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_txn: addr 0x%0h we %0d, none expected", mem_addr, mem_we);
        end else begin
          t = exp_q.pop_front();
          chk("txn_addr", mem_addr, t.addr);
          chk("txn_we", {63'b0, mem_we}, {63'b0, t.we});
          if (t.we) chk("txn_wdata", mem_wdata, t.wdata);
          chk("txn_cycle", 64'(cyc), 64'(t.cyc));
        end
      end
      prev_req = mem_req; prev_hs = mem_req && mem_ack;
      prev_addr = mem_addr; prev_we = mem_we; prev_wdata = mem_wdata;
      cyc++;
    end
  end

  // Expected fetch: completes after wait_n extra cycles, then one EXEC cycle.
  task automatic exp_fetch(input logic [63:0] a);
    exp_q.push_back('{we: 1'b0, addr: a, wdata: 64'h0, cyc: cursor + wait_n});
    cursor += wait_n + 2;
  endtask

  task automatic exp_mem(input logic we, input logic [63:0] a, input logic [63:0] wd);
    exp_q.push_back('{we: we, addr: a, wdata: wd, cyc: cursor + wait_n});
    cursor += wait_n + 1;
  endtask

  task automatic chk_reg(input int idx, input logic [63:0] exp);
    dbg_raddr = 5'(idx);
    #1;
    chk($sformatf("x%0d", idx), dbg_rdata, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_mem_req", {63'b0, mem_req}, 64'h0);
    chk("rst_halt_illegal", {62'b0, halt, illegal}, 64'h0);
    chk("rst_mem_addr", mem_addr, 64'h0);
    exp_q.delete();
    mem.delete();
    cursor = 0;
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic run_to_halt(input string name);
    int n = 0;
    while (!halt && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_halted"}, {63'b0, halt}, 64'h1);
    chk({name, "_sb_drained"}, 64'(exp_q.size()), 64'h0);
    chk({name, "_halt_req_low"}, {63'b0, mem_req}, 64'h0);
  endtask

  initial begin
    int n;
    reset = 1'b1; dbg_raddr = '0; mem_ack = 1'b0; mem_rdata = '0;

    // Straight-line arithmetic, zero-wait.
    do_reset(); wait_n = 0;
    mem[64'h00] = 64'h0050_0093; // addi x1,x0,5
    mem[64'h04] = 64'hFFD0_0113; // addi x2,x0,-3
    mem[64'h08] = 64'h0020_81B3; // add  x3,x1,x2
    mem[64'h0C] = 64'h4020_82B3; // sub  x5,x1,x2
    mem[64'h10] = 64'h0010_0073; // ebreak
    exp_fetch(64'h00); exp_fetch(64'h04); exp_fetch(64'h08);
    exp_fetch(64'h0C); exp_fetch(64'h10);
    release_reset();
    run_to_halt("arith");
    chk("arith_illegal", {63'b0, illegal}, 64'h0);
    chk_reg(1, 64'd5); chk_reg(2, 64'hFFFF_FFFF_FFFF_FFFD);
    chk_reg(3, 64'd2); chk_reg(5, 64'd8); chk_reg(0, 64'h0);

    // LUI sign extension.
    do_reset(); wait_n = 0;
    mem[64'h00] = 64'h8000_00B7; // lui x1,0x80000
    mem[64'h04] = 64'h0010_0073;
    exp_fetch(64'h00); exp_fetch(64'h04);
    release_reset();
    run_to_halt("lui");
    chk_reg(1, 64'hFFFF_FFFF_8000_0000);

    // Store then load with three wait cycles on every transaction.
    do_reset(); wait_n = 3;
    mem[64'h00] = 64'h1234_50B7; // lui  x1,0x12345
    mem[64'h04] = 64'h6780_8093; // addi x1,x1,0x678
    mem[64'h08] = 64'h1000_0113; // addi x2,x0,0x100
    mem[64'h0C] = 64'h0011_3423; // sd   x1,8(x2)
    mem[64'h10] = 64'h0081_3203; // ld   x4,8(x2)
    mem[64'h14] = 64'h0010_0073;
    exp_fetch(64'h00); exp_fetch(64'h04); exp_fetch(64'h08); exp_fetch(64'h0C);
    exp_mem(1'b1, 64'h108, 64'h1234_5678);
    exp_fetch(64'h10);
    exp_mem(1'b0, 64'h108, 64'h0);
    exp_fetch(64'h14);
    release_reset();
    run_to_halt("ldst");
    chk("ldst_memory", mem.exists(64'h108) ? mem[64'h108] : 64'h0, 64'h1234_5678);
    chk_reg(4, 64'h1234_5678);

    // Signed BGE not taken, BEQ backwards taken.
    do_reset(); wait_n = 0;
    mem[64'h00] = 64'hFFF0_0093; // addi x1,x0,-1
    mem[64'h04] = 64'h0010_0113; // addi x2,x0,1
    mem[64'h08] = 64'h0380_006F; // jal  x0,+0x38 -> 0x40
    mem[64'h40] = 64'h0020_D863; // bge  x1,x2,+16
    mem[64'h44] = 64'hFE00_0CE3; // beq  x0,x0,-8 -> 0x3C
    mem[64'h3C] = 64'h0010_0073;
    exp_fetch(64'h00); exp_fetch(64'h04); exp_fetch(64'h08);
    exp_fetch(64'h40); exp_fetch(64'h44); exp_fetch(64'h3C);
    release_reset();
    run_to_halt("branch");
    chk("branch_illegal", {63'b0, illegal}, 64'h0);

    // JAL link, then misaligned JALR target.
    do_reset(); wait_n = 0;
    mem[64'h00] = 64'h0200_006F; // jal  x0,+0x20
    mem[64'h20] = 64'h0100_00EF; // jal  x1,+16 -> 0x30
    mem[64'h30] = 64'h0020_0067; // jalr x0,2(x0)
    exp_fetch(64'h00); exp_fetch(64'h20); exp_fetch(64'h30);
    release_reset();
    run_to_halt("jump");
    chk("jump_illegal", {63'b0, illegal}, 64'h1);
    chk_reg(1, 64'h24);

    // JALR with rd == rs1, then misaligned load (no access, no write).
    do_reset(); wait_n = 1;
    mem[64'h00] = 64'h0100_0293; // addi x5,x0,16
    mem[64'h04] = 64'h0002_82E7; // jalr x5,0(x5)
    mem[64'h10] = 64'h0040_3303; // ld   x6,4(x0)
    exp_fetch(64'h00); exp_fetch(64'h04); exp_fetch(64'h10);
    release_reset();
    run_to_halt("misal");
    chk("misal_illegal", {63'b0, illegal}, 64'h1);
    chk_reg(5, 64'h8); chk_reg(6, 64'h0);

    // Reset pulsed while a load is waiting for its ack.
    do_reset(); wait_n = 5;
    mem[64'h000] = 64'h0070_0213; // addi x4,x0,7
    mem[64'h004] = 64'h1000_3203; // ld   x4,0x100(x0)
    mem[64'h008] = 64'h0010_0073;
    mem[64'h100] = 64'hDEAD_BEEF_0123_4567;
    exp_fetch(64'h00); exp_fetch(64'h04);
    release_reset();
    n = 0;
    while (!(mem_req && !mem_we && mem_addr == 64'h100) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("abort_reached_mem", 64'(n < 100), 64'h1);
    chk_reg(4, 64'h7);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_req_low", {63'b0, mem_req}, 64'h0);
    chk_reg(4, 64'h0);
    @(posedge clk); #1;
    chk("abort_sb_drained", 64'(exp_q.size()), 64'h0);
    cursor = 0;
    exp_fetch(64'h00); exp_fetch(64'h04);
    exp_mem(1'b0, 64'h100, 64'h0);
    exp_fetch(64'h08);
    reset = 1'b0;
    #1;
    chk("restart_req", {63'b0, mem_req}, 64'h1);
    chk("restart_addr", mem_addr, 64'h0);
    chk_reg(4, 64'h0);
    run_to_halt("restart");
    chk_reg(4, 64'hDEAD_BEEF_0123_4567);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
